// File: rtl/ram_dp.sv
// Simple-dual-port byte-masked RAM that zero-fills itself after reset and holds ready low until done.
// Optional macro RAM_FORWARD_EN: write-first forwarding on same-address collisions (read-first otherwise).
module ram_dp #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic                    wr,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [DATA_BYTES-1:0]   wr_mask,
  input  logic [8*DATA_BYTES-1:0] wr_data,
  input  logic                    rd,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    dbg_state_o
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_q, clr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [W-1:0]          rd_data_q, rd_data_d;
  logic [W-1:0]          mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [DATA_BYTES-1:0] mem_wmask;
  logic [W-1:0]          mem_wdata;
  logic [W-1:0]          rd_word;

  assign ready       = (state_q == IDLE);
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign dbg_state_o = state_q;

  // Handshake: requests are accepted only on edges where ready is already 1;
  // a read accepted on edge k is presented with rd_valid=1 for the cycle after edge k.
`ifdef RAM_FORWARD_EN
  always_comb begin
    rd_word = mem_q[rd_addr];
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (wr && (wr_addr == rd_addr) && wr_mask[i]) begin
        rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end
`else
  always_comb begin
    rd_word = mem_q[rd_addr];
  end
`endif

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wmask  = wr_mask;
    mem_wdata  = wr_data;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wmask = '1;
        mem_wdata = '0;
        // Counter stops on the last address instead of wrapping.
        if (clr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_d = clr_q + ADDR_BITS'(1);
        end
      end
      IDLE: begin
        mem_we = wr;
        if (rd) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_word;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array is left unreset; the clear sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (mem_wmask[i]) begin
          mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp (ADDR_BITS=4, DATA_BYTES=4): directed vectors, expected reads queued
// at issue time and checked by an independent monitor whenever rd_valid is high.
module tb_ram_dp;

  localparam int AB = 4;
  localparam int DB = 4;
  localparam int W  = 8 * DB;

  logic          clk;
  logic          rst;
  logic          ready;
  logic          wr;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_mask;
  logic [W-1:0]  wr_data;
  logic          rd;
  logic [AB-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          dbg_state;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;

  ram_dp #(.ADDR_BITS(AB), .DATA_BYTES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .wr         (wr),
    .wr_addr    (wr_addr),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data),
    .rd         (rd),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd = 1'b0; rd_addr = '0;
  endtask

  task automatic drive_wr(input logic [AB-1:0] a, input logic [W-1:0] d, input logic [DB-1:0] m);
    wr = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  task automatic drive_rd(input logic [AB-1:0] a, input logic [W-1:0] exp);
    rd = 1'b1; rd_addr = a;
    exp_q.push_back(exp);
  endtask

  // Counts edges after reset release; ready must be low for 15 edges and rise on the 16th.
  task automatic wait_clear(input string tag, input bit gate_traffic);
    for (int n = 1; n <= 16; n++) begin
      step();
      check({tag, "_ready"}, W'(ready), W'(n == 16));
      check({tag, "_rdv_clear"}, W'(rd_valid), '0);
      if (n == 16) idle_inputs();
      else if (gate_traffic) begin
        wr = 1'b1; wr_addr = 4'd7; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
        rd = 1'b1; rd_addr = 4'd7;
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid: got rd_data 0x%08h, no request outstanding", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    check("rst_ready", W'(ready), '0);
    check("rst_rd_valid", W'(rd_valid), '0);
    check("rst_rd_data", rd_data, '0);

    // Release reset with write/read traffic held on 7 during the clear.
    rst = 1'b0;
    drive_wr(4'd7, 32'hDEADBEEF, 4'hF);
    rd = 1'b1; rd_addr = 4'd7;
    wait_clear("clr1", 1'b1);

    // Every word reads zero, including the gated address 7.
    for (int i = 0; i < 16; i++) begin
      drive_rd(AB'(i), 32'h0);
      step();
    end
    idle_inputs();
    step();

    // Masked write
    drive_wr(4'd5, 32'hAABBCCDD, 4'b1111);
    step();
    drive_wr(4'd5, 32'h11223344, 4'b0101);
    step();
    idle_inputs();
    drive_rd(4'd5, 32'hAA22CC44);
    step();
    idle_inputs();
    step();

    // Zero mask leaves the word untouched
    drive_wr(4'd5, 32'h55555555, 4'b0000);
    step();
    idle_inputs();
    drive_rd(4'd5, 32'hAA22CC44);
    step();
    idle_inputs();
    step();

    // Collision
    drive_wr(4'd3, 32'h01020304, 4'hF);
    step();
`ifdef RAM_FORWARD_EN
    drive_rd(4'd3, 32'h0102FFFF);
`else
    drive_rd(4'd3, 32'h01020304);
`endif
    drive_wr(4'd3, 32'hFFFFFFFF, 4'b0011);
    step();
    idle_inputs();
    drive_rd(4'd3, 32'h0102FFFF);
    step();
    idle_inputs();
    step();
    check("rd_data_hold", rd_data, 32'h0102FFFF);
    check("rd_valid_drop", W'(rd_valid), '0);

    // Back-to-back streaming: write i one cycle ahead of reading it
    base = resp_cnt;
    for (int c = 0; c <= 17; c++) begin
      if (c >= 2) check("stream_rd_valid", W'(rd_valid), W'(1));
      idle_inputs();
      if (c < 16) drive_wr(AB'(c), W'(32'h100 + c), 4'hF);
      if (c >= 1 && c <= 16) drive_rd(AB'(c - 1), W'(32'h100 + c - 1));
      step();
    end
    idle_inputs();
    step();
    check("stream_resp_cnt", W'(resp_cnt - base), W'(16));

    // Reset mid-operation with a read pending
    drive_wr(4'd9, 32'h12345678, 4'hF);
    step();
    idle_inputs();
    rd = 1'b1; rd_addr = 4'd9;
    rst = 1'b1;
    step();
    check("midrst_rd_valid", W'(rd_valid), '0);
    check("midrst_rd_data", rd_data, '0);
    check("midrst_ready", W'(ready), '0);
    rst = 1'b0;
    idle_inputs();
    wait_clear("clr2", 1'b0);
    drive_rd(4'd9, 32'h0);
    step();
    idle_inputs();

    // Drain: every queued response must have arrived within a short budget.
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) step();
    step();
    check("queue_drained", W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
# ram_dp

Parametrised simple-dual-port RAM with byte-lane write masks: one write port and one read port, usable in the same cycle. After reset it zero-fills itself, and a ready flag gates all accesses until the fill finishes. It replaces the single-port byte-masked RAM wherever a fetch/load path needs to read while a store path writes. Examples are unified instruction/data memory and frame buffers.

## Interface
Parameters:
- ADDR_BITS, 10, word address width; depth = 2**ADDR_BITS words
- DATA_BYTES, 4, bytes per word; data width = 8*DATA_BYTES, mask width = DATA_BYTES

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  1 = memory initialised, requests accepted
- wr  in  1  write request
- wr_addr  in  ADDR_BITS  write word address
- wr_mask  in  DATA_BYTES  byte-lane enables; bit i covers data bits [8i+7:8i]
- wr_data  in  8*DATA_BYTES  write data
- rd  in  1  read request
- rd_addr  in  ADDR_BITS  read word address
- rd_data  out  8*DATA_BYTES  read data, registered
- rd_valid  out  1  rd_data holds the response to a request accepted on the previous edge

## Operation
- FSM has two states: CLEAR and IDLE.
- CLEAR:
  - A counter clr_addr writes all-zero words to every address, ascending, one word per cycle.
  - ready=0. wr and rd are ignored: no write occurs and rd_valid stays 0.
- CLEAR -> IDLE: on the edge that writes address 2**ADDR_BITS-1. ready=1 from that edge on.
- IDLE:
  - A write with wr=1 updates only the lanes whose wr_mask bit is 1. wr_mask=0 with wr=1 is legal and changes nothing.
  - A read with rd=1 captures the word at rd_addr into rd_data and sets rd_valid=1 on the same edge.
  - rd=0 sets rd_valid=0 on the next edge and holds rd_data at its last value.
- Reads and writes are independent and may both be issued every cycle.
- Collision: wr=1 and rd=1 at the same address in the same cycle. Behaviour depends on the Configuration macro.
- rst=1 on any edge, in any state (including mid-clear or mid-traffic):
  - state=CLEAR, clr_addr=0, ready=0, rd_valid=0, rd_data=0.
  - No memory write happens on that edge.
  - The clear restarts from address 0 on the first edge with rst=0.
- Reset values: ready=0, rd_valid=0, rd_data=0.
- The address counter is ADDR_BITS wide; no wrap past the last address is ever taken.

## Timing
- Read latency is 1 cycle. A request sampled on edge k gives rd_data/rd_valid visible after edge k, and the response lasts one cycle unless rd stays high.
- Clear duration is 2**ADDR_BITS edges. The first edge with rst=0 writes address 0. ready rises after edge number 2**ADDR_BITS counted from rst release.
- Requests are sampled only when ready=1 at the edge. A request presented on the edge where ready rises is ignored.
- A write is visible to a non-colliding read on the next edge: write on edge k, read issued on edge k+1 returns the new data.
- There is no backpressure: ready, once high, stays high until rst.

## Configuration
- RAM_FORWARD_EN defined (write-first):
  - On a same-address collision, rd_data returns the merged word: new bytes in lanes with wr_mask=1, old stored bytes elsewhere.
  - Forwarding adds no latency and must not lengthen the memory read path beyond one mux after the array.
- RAM_FORWARD_EN undefined (read-first): on a collision, rd_data returns the full old word. The write still commits.
- Both builds behave the same for every non-colliding access.

## Test plan
Unless stated otherwise, the bench runs ADDR_BITS=4, DATA_BYTES=4.
- Reset/clear: hold rst 3 cycles, release -> ready=0 for exactly 16 edges, then 1. Then read all 16 addresses -> every read returns 0x00000000 with rd_valid=1 one cycle after its request.
- Masked write: wr addr 5, data 0xAABBCCDD, mask 4'b1111; then wr addr 5, data 0x11223344, mask 4'b0101; then rd addr 5 -> rd_data=0xAA22CC44.
- Collision: preload addr 3 = 0x01020304; same cycle wr addr 3, data 0xFFFFFFFF, mask 4'b0011, and rd addr 3 -> rd_data=0x0102FFFF with RAM_FORWARD_EN, 0x01020304 without. A following rd addr 3 returns 0x0102FFFF in both builds.
- Gating: issue wr addr 7, data 0xDEADBEEF, mask 4'hF, and rd addr 7 during CLEAR -> rd_valid stays 0. After ready, rd addr 7 -> 0x00000000.
- Reset mid-operation: after ready, write addr 9 = 0x12345678; assert rst 1 cycle while rd addr 9 is pending -> rd_valid=0, rd_data=0, ready=0. After 16 more edges ready=1, and rd addr 9 -> 0x00000000.
- Back-to-back streaming: rd on addrs 0..15 in consecutive cycles while writing addr i with value i+0x100 one cycle ahead of each read -> rd_valid stays 1 for 16 cycles, and each read returns 0x100+i.
